// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the SPI-flash-to-cache boot loader.
package flash_loader_pkg;

  typedef enum logic [2:0] {
    StWait,
    StCmd,
    StAddr,
    StDummy,
    StRead,
    StWrite,
    StFinish,
    StIdle
  } state_e;

  localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
  localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;

  // Valid-byte count (1..4) to cache byte-lane enables, low lanes first.
  function automatic logic [3:0] lane_mask(input logic [2:0] n);
    case (n)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// Full-duplex 8-bit SPI mode-0 shifter with a CLK_DIV half-period divider.
module spi_byte_xfer #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte
);
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [7:0]      tx_q, rx_q;
  logic [2:0]      bit_q;
  logic [DivW-1:0] div_q;
  logic            sck_q, mosi_q, busy_q;
  logic            phase_end;

  assign phase_end = busy_q && (div_q == DivLast);
  // Done fires on the edge that samples the last bit, so the caller can
  // queue the next byte before the trailing falling edge.
  assign done    = phase_end && !sck_q && (bit_q == 3'd7);
  assign rx_byte = {rx_q[6:0], miso};
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q   <= '0;
      rx_q   <= '0;
      bit_q  <= '0;
      div_q  <= '0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (!busy_q) begin
      if (start) begin
        busy_q <= 1'b1;
        tx_q   <= tx_byte;
        mosi_q <= tx_byte[7];
        bit_q  <= '0;
        div_q  <= '0;
      end
    end else if (phase_end) begin
      div_q <= '0;
      if (!sck_q) begin
        sck_q <= 1'b1;
        rx_q  <= {rx_q[6:0], miso};
      end else begin
        sck_q <= 1'b0;
        if (bit_q == 3'd7) begin
          // Back-to-back bytes continue without an extra low phase.
          if (start) begin
            tx_q   <= tx_byte;
            mosi_q <= tx_byte[7];
            bit_q  <= '0;
          end else begin
            busy_q <= 1'b0;
          end
        end else begin
          bit_q  <= bit_q + 3'd1;
          tx_q   <= {tx_q[6:0], 1'b0};
          mosi_q <= tx_q[6];
        end
      end
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

endmodule

// File: rtl/flash_loader.sv
// SPI flash to cache boot loader. Define FLASH_LOADER_CHECKSUM_EN to add the
// running byte-sum output port 'checksum'.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int unsigned CLK_DIV          = 1,
  parameter int unsigned STARTUP_WAIT     = 1_000_000,
  parameter logic [23:0] FLASH_START_ADDR = 24'h00_0000,
  parameter logic [31:0] DST_START_ADDR   = 32'h0000_0000,
  parameter int unsigned TRANSFER_BYTES   = 16,
  parameter bit          FAST_READ        = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        flash_clk,
  output logic        flash_mosi,
  output logic        flash_cs,
  input  logic        flash_miso,
  output logic [31:0] cache_address,
  output logic [31:0] cache_data_in,
  output logic [3:0]  cache_write_enable,
  input  logic        cache_busy,
  output logic        done,
`ifdef FLASH_LOADER_CHECKSUM_EN
  output logic [31:0] checksum,
`endif
  output logic [31:0] bytes_loaded
);
  state_e      state_q, state_d;
  logic [31:0] wait_q, wait_d, rcvd_q, rcvd_d, word_q, word_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, loaded_q, loaded_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  lane_q, lane_d;
  logic [3:0]  we_q, we_d;
  logic        done_q, done_d, first_q, first_d, cs_q;

  logic       spi_start, spi_busy, spi_done;
  logic [7:0] spi_tx, spi_rx;

  spi_byte_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk     (clk),
    .rst     (rst),
    .start   (spi_start),
    .tx_byte (spi_tx),
    .miso    (flash_miso),
    .sck     (flash_clk),
    .mosi    (flash_mosi),
    .busy    (spi_busy),
    .done    (spi_done),
    .rx_byte (spi_rx)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    rcvd_d    = rcvd_q;
    word_d    = word_q;
    addr_d    = addr_q;
    data_d    = data_q;
    loaded_d  = loaded_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    we_d      = we_q;
    done_d    = done_q;
    first_d   = first_q;
    spi_start = 1'b0;
    spi_tx    = 8'h00;
    unique case (state_q)
      StWait: begin
        if (wait_q + 32'd1 >= 32'(STARTUP_WAIT)) state_d = StCmd;
        else wait_d = wait_q + 32'd1;
      end
      StCmd: begin
        spi_start = 1'b1;
        spi_tx    = FAST_READ ? FLASH_CMD_FAST_READ : FLASH_CMD_READ;
        if (spi_done) begin
          state_d = StAddr;
          idx_d   = 2'd0;
        end
      end
      StAddr: begin
        spi_start = 1'b1;
        case (idx_q)
          2'd0:    spi_tx = FLASH_START_ADDR[23:16];
          2'd1:    spi_tx = FLASH_START_ADDR[15:8];
          default: spi_tx = FLASH_START_ADDR[7:0];
        endcase
        if (spi_done) begin
          if (idx_q == 2'd2) state_d = FAST_READ ? StDummy : StRead;
          else idx_d = idx_q + 2'd1;
        end
      end
      StDummy: begin
        spi_start = 1'b1;
        if (spi_done) state_d = StRead;
      end
      StRead: begin
        spi_start = 1'b1;
        if (spi_done) begin
          word_d = word_q | (32'(spi_rx) << {lane_q[1:0], 3'b000});
          lane_d = lane_q + 3'd1;
          rcvd_d = rcvd_q + 32'd1;
          if (lane_q == 3'd3 || rcvd_d == 32'(TRANSFER_BYTES)) begin
            state_d = StWrite;
            first_d = 1'b1;
            // Only the final word can be partial, so loaded_q is 4 * word index here.
            addr_d  = DST_START_ADDR + loaded_q;
            data_d  = word_d;
            we_d    = lane_mask(lane_d);
          end
        end
      end
      StWrite: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!cache_busy) begin
          we_d     = 4'b0000;
          loaded_d = loaded_q + 32'(lane_q);
          addr_d   = addr_q + 32'd4;
          word_d   = '0;
          lane_d   = '0;
          state_d  = (rcvd_q == 32'(TRANSFER_BYTES)) ? StFinish : StRead;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StIdle: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StWait;
      wait_q   <= '0;
      rcvd_q   <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      loaded_q <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      we_q     <= '0;
      done_q   <= 1'b0;
      first_q  <= 1'b0;
      cs_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rcvd_q   <= rcvd_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      loaded_q <= loaded_d;
      idx_q    <= idx_d;
      lane_q   <= lane_d;
      we_q     <= we_d;
      done_q   <= done_d;
      first_q  <= first_d;
      // Keep CS low until the shifter has parked SCK after the last bit.
      cs_q     <= !((state_d inside {StCmd, StAddr, StDummy, StRead, StWrite}) || spi_busy);
    end
  end

`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else if (state_q == StRead && spi_done) csum_q <= csum_q + 32'(spi_rx);
  end
  assign checksum = csum_q;
`endif

  assign flash_cs           = cs_q;
  assign cache_address      = addr_q;
  assign cache_data_in      = data_q;
  assign cache_write_enable = we_q;
  assign done               = done_q;
  assign bytes_loaded       = loaded_q;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench: four loader configurations, each with its own SPI flash model.
module tb_flash_loader;
  localparam int N = 4;
  // 0: basic 8 bytes with cache stalls; 1: partial word; 2: fast read, div 3, wrap; 3: reset abort
  localparam int unsigned CD [N] = '{1, 1, 3, 1};
  localparam bit          FR [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [23:0] FSA [N] = '{24'h0, 24'h0, 24'h10_0000, 24'h0};
  localparam logic [31:0] DSA [N] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'h100};
  localparam int unsigned TBY [N] = '{8, 6, 12, 8};
  localparam int unsigned NW  [N] = '{2, 2, 3, 2};
  localparam logic [31:0] EXP_HDR [N] = '{32'h0300_0000, 32'h0300_0000, 32'h0B10_0000, 32'h0300_0000};
  localparam logic [31:0] EXP_SUM [N] = '{32'h1A4, 32'h135, 32'h34E, 32'h1A4};
  localparam logic [31:0] EXP_ADDR [N][3] = '{
    '{32'h0, 32'h4, 32'h0}, '{32'h0, 32'h4, 32'h0},
    '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0}, '{32'h100, 32'h104, 32'h0}};
  localparam logic [31:0] EXP_DATA [N][3] = '{
    '{32'h3433_3231, 32'h3837_3635, 32'h0}, '{32'h3433_3231, 32'h0000_3635, 32'h0},
    '{32'h4443_4241, 32'h4847_4645, 32'h4C4B_4A49}, '{32'h3433_3231, 32'h3837_3635, 32'h0}};
  localparam logic [3:0] EXP_WE [N][3] = '{
    '{4'hF, 4'hF, 4'h0}, '{4'hF, 4'h3, 4'h0}, '{4'hF, 4'hF, 4'hF}, '{4'hF, 4'hF, 4'h0}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst = '1;
  logic [N-1:0] done_v, cs_v;
  logic [31:0]  bl_v [N];
  logic [31:0]  sum_v [N];
  int           wr_v [N];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Flash contents: a distinct byte per address, offset by the 64K page.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    return 8'h31 + a[7:0] + a[23:16];
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic        fclk, fmosi, fcs, busy, done;
    logic        fmiso = 1'b0;
    logic [31:0] addr, data, bl;
    logic [3:0]  we;
    int unsigned bitn = 0;
    logic [31:0] hdr = '0;
    logic [7:0]  dmy = '0;
    int          wr_n = 0, busy_cnt = 0, run = 0;
    logic        last_sck = 1'b0, done_p = 1'b0;
    logic [3:0]  we_p1 = '0, we_p2 = '0;

    initial busy = 1'b0;

`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [31:0] csum;
    assign sum_v[g] = csum;
`else
    assign sum_v[g] = EXP_SUM[g];
`endif

    flash_loader #(
      .CLK_DIV          (CD[g]),
      .STARTUP_WAIT     (10),
      .FLASH_START_ADDR (FSA[g]),
      .DST_START_ADDR   (DSA[g]),
      .TRANSFER_BYTES   (TBY[g]),
      .FAST_READ        (FR[g])
    ) u_dut (
      .clk                (clk),
      .rst                (rst[g]),
      .flash_clk          (fclk),
      .flash_mosi         (fmosi),
      .flash_cs           (fcs),
      .flash_miso         (fmiso),
      .cache_address      (addr),
      .cache_data_in      (data),
      .cache_write_enable (we),
      .cache_busy         (busy),
      .done               (done),
`ifdef FLASH_LOADER_CHECKSUM_EN
      .checksum           (csum),
`endif
      .bytes_loaded       (bl)
    );

    assign done_v[g] = done;
    assign cs_v[g]   = fcs;
    assign bl_v[g]   = bl;
    assign wr_v[g]   = wr_n;

    // Flash slave: samples MOSI on SCK rise, shifts MISO on SCK fall.
    always @(posedge fclk or posedge fcs) begin
      if (fcs) begin
        bitn = 0;
      end else begin
        if (bitn < 32) hdr = {hdr[30:0], fmosi};
        else if (bitn < 40 && hdr[31:24] == 8'h0B) dmy = {dmy[6:0], fmosi};
        bitn++;
        if (bitn == 32) check($sformatf("g%0d cmd+addr", g), hdr, EXP_HDR[g]);
        if (bitn == 40 && hdr[31:24] == 8'h0B) check($sformatf("g%0d dummy", g), {24'h0, dmy}, 32'h0);
      end
    end

    always @(negedge fclk or negedge fcs) begin
      int unsigned hl, d;
      logic [7:0] b;
      hl = (hdr[31:24] == 8'h0B) ? 40 : 32;
      fmiso = 1'b0;
      if (!fcs && bitn >= hl) begin
        d = bitn - hl;
        b = fbyte(hdr[23:0] + 24'(d / 8));
        fmiso = b[3'(7 - d % 8)];
      end
    end

    always @(negedge clk) begin
      if (we != 4'h0 && we_p1 == 4'h0) begin
        if (wr_n < 3) begin
          check($sformatf("g%0d wr%0d addr", g, wr_n), addr, EXP_ADDR[g][wr_n]);
          check($sformatf("g%0d wr%0d data", g, wr_n), data, EXP_DATA[g][wr_n]);
          check($sformatf("g%0d wr%0d we", g, wr_n), {28'h0, we}, {28'h0, EXP_WE[g][wr_n]});
        end
        wr_n++;
        if (g == 0) busy_cnt = 20;
      end else if (we != 4'h0 && wr_n >= 1 && wr_n <= 3) begin
        check($sformatf("g%0d hold data", g), data, EXP_DATA[g][wr_n-1]);
        check($sformatf("g%0d hold addr", g), addr, EXP_ADDR[g][wr_n-1]);
      end
      if (busy) begin
        check($sformatf("g%0d we under busy", g), {31'h0, we != 4'h0}, 32'h1);
        check($sformatf("g%0d sck parked", g), {31'h0, fclk}, 32'h0);
      end
      if (rst[g]) begin
        run = 0;
        last_sck = fclk;
      end else if (fclk != last_sck) begin
        if (last_sck) check($sformatf("g%0d sck high len", g), run, CD[g]);
        else if (!fcs) check($sformatf("g%0d sck low len", g), {31'h0, run >= int'(CD[g])}, 32'h1);
        run = 1;
        last_sck = fclk;
      end else begin
        run++;
      end
      if (done && !done_p)
        check($sformatf("g%0d done timing", g), {30'h0, we_p1 == 4'h0, we_p2 != 4'h0}, 32'h3);
      done_p = done;
      we_p2 = we_p1;
      we_p1 = we;
      busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
  end

  initial begin
    int n;
    rst = '1;
    repeat (3) @(negedge clk);
    check("rst cs", {31'h0, g_dut[0].fcs}, 32'h1);
    check("rst sck", {31'h0, g_dut[0].fclk}, 32'h0);
    check("rst mosi", {31'h0, g_dut[0].fmosi}, 32'h0);
    check("rst we", {28'h0, g_dut[0].we}, 32'h0);
    check("rst addr", g_dut[0].addr, 32'h0);
    check("rst data", g_dut[0].data, 32'h0);
    check("rst done", {31'h0, g_dut[0].done}, 32'h0);
    check("rst bytes", g_dut[0].bl, 32'h0);
    rst = '0;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (g_dut[0].fcs && n < 100);
    check("startup wait", n, 10);

    // Abort configuration 3 partway through its third data byte.
    for (int i = 0; i < 2000 && g_dut[3].bitn < 50; i++) @(negedge clk);
    check("g3 reached byte 2", {31'h0, g_dut[3].bitn >= 50}, 32'h1);
    rst[3] = 1'b1;
    @(negedge clk);
    check("g3 abort cs", {31'h0, g_dut[3].fcs}, 32'h1);
    check("g3 abort we", {28'h0, g_dut[3].we}, 32'h0);
    check("g3 abort sck", {31'h0, g_dut[3].fclk}, 32'h0);
    check("g3 abort bytes", g_dut[3].bl, 32'h0);
    @(negedge clk);
    rst[3] = 1'b0;

    for (int i = 0; i < 5000 && done_v != '1; i++) @(negedge clk);
    check("all done", {28'h0, done_v}, 32'hF);
    repeat (5) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("g%0d bytes_loaded", k), bl_v[k], TBY[k]);
      check($sformatf("g%0d write count", k), wr_v[k], NW[k]);
      check($sformatf("g%0d cs idle", k), {31'h0, cs_v[k]}, 32'h1);
      check($sformatf("g%0d done held", k), {31'h0, done_v[k]}, 32'h1);
`ifdef FLASH_LOADER_CHECKSUM_EN
      check($sformatf("g%0d checksum", k), sum_v[k], EXP_SUM[k]);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
Parametrised SPI-flash-to-cache boot loader. After reset and a power-up wait, it issues a read command to the external SPI flash (mode 0). It streams TRANSFER_BYTES bytes from FLASH_START_ADDR and packs them little-endian into 32-bit words. Each word is written to the Cache at DST_START_ADDR upward through the cache write/busy handshake. It sits between the flash pins and the Cache in Top and replaces the inline loader state machine.

Parameters:
CLK_DIV, 1, SPI half-period in clk cycles (>=1); SCK period = 2*CLK_DIV cycles
STARTUP_WAIT, 1_000_000, clk cycles from reset release before the first CS assertion
FLASH_START_ADDR, 24'h00_0000, 24-bit flash source address
DST_START_ADDR, 32'h0000_0000, cache byte address of the first word
TRANSFER_BYTES, 16, bytes to copy (>=1, need not be a multiple of 4)
FAST_READ, 0, 0 = cmd 0x03, no dummy; 1 = cmd 0x0B followed by 8 dummy clocks

Ports:
clk  in  1  system clock (single domain)
rst  in  1  synchronous, active-high reset
flash_clk  out  1  SPI SCK, idle low
flash_mosi  out  1  SPI MOSI
flash_cs  out  1  SPI chip select, active low
flash_miso  in  1  SPI MISO
cache_address  out  32  write byte address (word aligned)
cache_data_in  out  32  write data
cache_write_enable  out  4  byte-lane write enables
cache_busy  in  1  cache busy
done  out  1  transfer complete, sticky until reset
bytes_loaded  out  32  count of bytes committed to cache

Behaviour:
- Reset (synchronous, active-high, checked every edge, overrides everything): flash_clk=0, flash_mosi=0, flash_cs=1, cache_address=0, cache_data_in=0, cache_write_enable=0, done=0, bytes_loaded=0, state=WAIT.
- A reset asserted mid-transfer aborts it immediately: CS goes high at the next edge and the pending write_enable is dropped. No partial state is retained.
- States:
  - WAIT: count up to STARTUP_WAIT, then go to CMD.
  - CMD: CS=0 and shift the command byte.
  - ADDR: shift the 24 address bits, MSB first.
  - DUMMY: only when FAST_READ=1; 8 clocks with MOSI=0.
  - READ: shift in bytes.
  - WRITE: hold the cache write.
  - FINISH: CS=1, done=1.
  - IDLE: terminal state.
- SPI timing (mode 0): MOSI updates with the SCK falling edge. MISO is sampled in the same clk edge that drives SCK high. Each phase lasts CLK_DIV cycles. Bits are MSB first. Flash CS stays low from CMD through the last data bit; it does not toggle during WRITE stalls, and SCK stays low while stalled.
- Packing: byte k of a word goes to cache_data_in[8k+7:8k], with the first flash byte in lane 0.
- Write trigger: WRITE is entered after 4 bytes, or when the last byte has arrived.
- Write enable: 4'b1111 for full words. For a partial final word, only the valid low lanes are enabled (TRANSFER_BYTES=6 gives a final mask of 4'b0011). Unused lanes carry 0.
- Handshake: address, data and mask are driven in the cycle WRITE is entered (cycle T) and held stable. cache_busy is ignored in cycle T. From T+1 onward, the first cycle with cache_busy=0 completes the write. On that edge, write_enable clears to 0, bytes_loaded increases by the number of valid bytes, and the address advances by 4.
- Cache address sequence: DST_START_ADDR, +4, ... The address is 32 bits and wraps modulo 2^32.
- After the final write the state goes to FINISH. done rises one cycle after the final write_enable clears and then holds. flash_cs=1 from FINISH onward.
- Flash address overflow: the flash wraps at 2^24 internally; the loader does not track it.

Optional Feature:
Macro FLASH_LOADER_CHECKSUM_EN.
- Defined: adds the output port checksum [31:0], reset 0. It is the 32-bit wrapping sum of every byte received and is updated as each byte completes. Its value is final when done=1.
- Undefined: the port and the adder are absent.

Decomposition:
- Package flash_loader_pkg holds:
  - a state enum typedef (WAIT, CMD, ADDR, DUMMY, READ, WRITE, FINISH, IDLE);
  - constants FLASH_CMD_READ=8'h03 and FLASH_CMD_FAST_READ=8'h0B;
  - a function mapping valid-byte count (1..4) to the lane mask.
- One sub-module, spi_byte_xfer, is the natural split. It does a full-duplex 8-bit SPI mode-0 shift with the CLK_DIV divider and a start/busy/done pulse interface. It handles TX and RX, and also the dummy byte.

Test Plan:
- STARTUP_WAIT=10, CLK_DIV=1, FAST_READ=0, TRANSFER_BYTES=8, flash model holding 0x31..0x38 at address 0, cache_busy low -> MOSI sends 0x03,0x00,0x00,0x00; writes are (0x0,0x34333231,4'b1111) then (0x4,0x38373635,4'b1111); done=1; bytes_loaded=8.
- TRANSFER_BYTES=6 -> second write is (0x4,0x00003635,4'b0011); bytes_loaded=6.
- FAST_READ=1, FLASH_START_ADDR=24'h10_0000, CLK_DIV=3 -> MOSI sends 0x0B,0x10,0x00,0x00 then 8 dummy clocks; SCK high/low phases each last 3 cycles; data is read from 0x100000.
- cache_busy held high for 20 cycles after each write -> write_enable and data stay stable throughout; the next SCK edge appears only after busy falls; the data stream is unchanged.
- rst pulsed during the third byte of READ -> next edge gives flash_cs=1 and write_enable=0; after release the loader restarts from WAIT and the first write is again at DST_START_ADDR.
- With FLASH_LOADER_CHECKSUM_EN defined, bytes 0x31..0x38 -> checksum=0x0000_01A4 when done=1.
